// File: rtl/bist_pkg.sv
// Shared BIST definitions: compactor FSM states, default MISR constants and the
// signature update function also used by the pattern-generator LFSR.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CMP,
        DONE
    } state_t;

    // Widest register the shared update function supports.
    localparam int MAX_W = 32;

    localparam int          DEF_SIG_W = 16;
    localparam logic [15:0] DEF_POLY  = 16'h1021;
    localparam logic [15:0] DEF_SEED  = 16'hFFFF;

    // One MISR/LFSR step on a register of 'width' bits held in the low bits of
    // MAX_W-wide operands: shift left, fold the taps if the shifted-out MSB was
    // set, XOR the input word, then drop everything above 'width'.
    function automatic logic [MAX_W-1:0] misr_next(
        input logic [MAX_W-1:0] sig,
        input logic [MAX_W-1:0] resp,
        input logic [MAX_W-1:0] poly,
        input int unsigned      width
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] msb_word;
        mask     = {MAX_W{1'b1}} >> (MAX_W - width);
        msb_word = sig >> (width - 1);
        return ((sig << 1) ^ (msb_word[0] ? poly : '0) ^ resp) & mask;
    endfunction

endpackage

// File: rtl/resp_misr_compactor_misr.sv
// Signature register: loads SEED on reset or load, folds one response word per
// enabled cycle.
module misr_reg
    import bist_pkg::*;
#(
    parameter int               SIG_W  = DEF_SIG_W,
    parameter int               RESP_W = 2,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED   = SIG_W'(DEF_SEED)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic [RESP_W-1:0] resp,
    output logic [SIG_W-1:0]  sig
);

    logic [SIG_W-1:0] sig_next;

    assign sig_next = SIG_W'(misr_next(MAX_W'(sig), MAX_W'(resp), MAX_W'(POLY), SIG_W));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/resp_misr_compactor.sv
// BIST response compactor: start/busy/done FSM and pattern counter around a
// single MISR; compares the final signature against GOLDEN.
module resp_misr_compactor
    import bist_pkg::*;
#(
    parameter int               RESP_W  = 2,
    parameter int               SIG_W   = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY    = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED    = SIG_W'(DEF_SEED),
    parameter int               NUM_PAT = 32,
    parameter logic [SIG_W-1:0] GOLDEN  = '0,
    localparam int              CNT_W   = $clog2(NUM_PAT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  pat_cnt
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PAT - 1);

    state_t state_q;
    state_t state_d;
    logic   run_load;
    logic   accept;

    // start is honoured only outside an active run.
    assign run_load = start && (state_q == IDLE || state_q == DONE);
    assign accept   = (state_q == RUN) && resp_valid;

    // NOTE: next-state is given a default before the case so no path through
    // the combinational block can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start) state_d = RUN;
            RUN:        if (accept && pat_cnt == LAST_CNT) state_d = CMP;
            CMP:        state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_cnt <= '0;
            pass    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (run_load) begin
                pat_cnt <= '0;
                pass    <= 1'b0;
            end else begin
                if (accept) pat_cnt <= pat_cnt + 1'b1;
                if (state_q == CMP) pass <= (signature == GOLDEN);
            end
        end
    end

    assign busy = (state_q == RUN) || (state_q == CMP);
    assign done = (state_q == DONE);

    misr_reg #(
        .SIG_W  (SIG_W),
        .RESP_W (RESP_W),
        .POLY   (POLY),
        .SEED   (SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (run_load),
        .en   (accept),
        .resp (resp),
        .sig  (signature)
    );

endmodule

// File: tb/tb_resp_misr_compactor.sv
// Self-checking bench for resp_misr_compactor: small-width directed cases plus
// c17 and random runs at default parameters against an arithmetic model.
module tb_resp_misr_compactor;

    // Reference MISR step written as integer arithmetic on a w-bit register.
    function automatic int model_step(input int sig, input int r, input int w, input int poly);
        int nxt;
        nxt = (sig * 2) % (1 << w);
        if (sig >= (1 << (w - 1))) nxt = nxt ^ poly;
        return nxt ^ r;
    endfunction

    // c17 benchmark: returns {G23gat, G22gat}.
    function automatic logic [1:0] c17(input logic [4:0] p);
        logic g1, g2, g3, g6, g7, g10, g11, g16, g19;
        {g7, g6, g3, g2, g1} = p;
        g10 = ~(g1 & g3);
        g11 = ~(g3 & g6);
        g16 = ~(g2 & g11);
        g19 = ~(g11 & g7);
        return {~(g16 & g19), ~(g10 & g16)};
    endfunction

    function automatic int c17_golden();
        int s;
        s = 'hFFFF;
        for (int i = 0; i < 32; i++) s = model_step(s, int'(c17(5'(i))), 16, 'h1021);
        return s;
    endfunction

    localparam logic [15:0] GOLDEN_D = 16'(c17_golden());

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // A: SIG_W=4, POLY=3, SEED=8, NUM_PAT=1, GOLDEN=3
    logic       a_start, a_valid, a_busy, a_done, a_pass;
    logic [1:0] a_resp;
    logic [3:0] a_sig;
    logic [0:0] a_cnt;
    // B/C: SIG_W=4, POLY=3, SEED=0, NUM_PAT=2, GOLDEN=1 (B) / 5 (C), shared stimulus
    logic       bc_start, bc_valid, b_busy, b_done, b_pass, c_busy, c_done, c_pass;
    logic [1:0] bc_resp, b_cnt, c_cnt;
    logic [3:0] b_sig, c_sig;
    // D: default parameters, GOLDEN = c17 reference signature
    logic        d_start, d_valid, d_busy, d_done, d_pass;
    logic [1:0]  d_resp;
    logic [15:0] d_sig;
    logic [5:0]  d_cnt;

    resp_misr_compactor #(.SIG_W(4), .POLY(4'h3), .SEED(4'h8), .NUM_PAT(1), .GOLDEN(4'h3)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .resp_valid(a_valid), .resp(a_resp),
        .busy(a_busy), .done(a_done), .pass(a_pass), .signature(a_sig), .pat_cnt(a_cnt));

    resp_misr_compactor #(.SIG_W(4), .POLY(4'h3), .SEED(4'h0), .NUM_PAT(2), .GOLDEN(4'h1)) dut_b (
        .clk(clk), .rst(rst), .start(bc_start), .resp_valid(bc_valid), .resp(bc_resp),
        .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig), .pat_cnt(b_cnt));

    resp_misr_compactor #(.SIG_W(4), .POLY(4'h3), .SEED(4'h0), .NUM_PAT(2), .GOLDEN(4'h5)) dut_c (
        .clk(clk), .rst(rst), .start(bc_start), .resp_valid(bc_valid), .resp(bc_resp),
        .busy(c_busy), .done(c_done), .pass(c_pass), .signature(c_sig), .pat_cnt(c_cnt));

    resp_misr_compactor #(.GOLDEN(GOLDEN_D)) dut_d (
        .clk(clk), .rst(rst), .start(d_start), .resp_valid(d_valid), .resp(d_resp),
        .busy(d_busy), .done(d_done), .pass(d_pass), .signature(d_sig), .pat_cnt(d_cnt));

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       start;
        logic       valid;
        logic [1:0] resp;
        logic [3:0] sig;
        logic [1:0] cnt;
        logic       busy;
        logic       done;
        logic       pass_b;
        logic       pass_c;
    } vec_t;

    vec_t tbl[7];

    task automatic check_d_reset(input string tag);
        check({tag, "_sig"},  32'(d_sig),  32'h0000FFFF);
        check({tag, "_cnt"},  32'(d_cnt),  32'd0);
        check({tag, "_busy"}, 32'(d_busy), 32'd0);
        check({tag, "_done"}, 32'(d_done), 32'd0);
        check({tag, "_pass"}, 32'(d_pass), 32'd0);
    endtask

    // One default-parameter run: start in the current cycle, 32 accepted
    // responses with random stalls. rst_after>0 aborts with rst after that many.
    task automatic run_d(input int rst_after, input bit use_c17, input bit poke);
        int         m_sig;
        logic [1:0] r;
        m_sig = 'hFFFF;
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        check("d_busy_start", 32'(d_busy), 32'd1);
        check("d_done_clr",   32'(d_done), 32'd0);
        check("d_pass_clr",   32'(d_pass), 32'd0);
        check("d_sig_seed",   32'(d_sig),  32'h0000FFFF);
        check("d_cnt_zero",   32'(d_cnt),  32'd0);
        for (int k = 0; k < 32; k++) begin
            repeat ($urandom_range(0, 2)) begin
                d_valid = 1'b0;
                d_resp  = 2'($urandom);
                d_start = poke & 1'($urandom);
                tick();
            end
            r = use_c17 ? c17(5'(k)) : 2'($urandom);
            d_valid = 1'b1;
            d_resp  = r;
            d_start = poke;
            tick();
            d_valid = 1'b0;
            d_start = 1'b0;
            m_sig = model_step(m_sig, int'(r), 16, 'h1021);
            check("d_sig", 32'(d_sig), 32'(m_sig[15:0]));
            check("d_cnt", 32'(d_cnt), 32'(k + 1));
            if (k + 1 == rst_after) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check_d_reset("d_midrst");
                return;
            end
        end
        check("d_cmp_busy", 32'(d_busy), 32'd1);
        check("d_cmp_done", 32'(d_done), 32'd0);
        d_valid = 1'b1;
        d_resp  = 2'($urandom);
        d_start = poke;
        tick();
        d_valid = 1'b0;
        d_start = 1'b0;
        check("d_done",     32'(d_done), 32'd1);
        check("d_busy_end", 32'(d_busy), 32'd0);
        check("d_pass",     32'(d_pass), 32'(m_sig[15:0] == GOLDEN_D));
        check("d_sig_end",  32'(d_sig),  32'(m_sig[15:0]));
        check("d_cnt_end",  32'(d_cnt),  32'd32);
    endtask

    initial begin
        rst = 1'b1;
        {a_start, a_valid, a_resp}    = '0;
        {bc_start, bc_valid, bc_resp} = '0;
        {d_start, d_valid, d_resp}    = '0;

        // Stall / mismatch sequence shared by B (GOLDEN=1) and C (GOLDEN=5).
        tbl[0] = '{1'b1, 1'b0, 2'b00, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 2'b01, 4'h1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 2'b11, 4'h1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 2'b11, 4'h1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 2'b11, 4'h1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 2'b00, 4'h1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 2'b10, 4'h1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0};

        tick();
        tick();
        check("a_rst_sig",  32'(a_sig),  32'h8);
        check("a_rst_cnt",  32'(a_cnt),  32'd0);
        check("a_rst_busy", 32'(a_busy), 32'd0);
        check("a_rst_done", 32'(a_done), 32'd0);
        check("a_rst_pass", 32'(a_pass), 32'd0);
        check_d_reset("d_rst");
        rst = 1'b0;

        // Feedback path with NUM_PAT=1.
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check("a_busy_start", 32'(a_busy), 32'd1);
        a_valid = 1'b1;
        a_resp  = 2'b00;
        tick();
        a_valid = 1'b0;
        check("a_sig_fb",   32'(a_sig),  32'h3);
        check("a_cmp_busy", 32'(a_busy), 32'd1);
        check("a_cmp_done", 32'(a_done), 32'd0);
        tick();
        check("a_done",     32'(a_done), 32'd1);
        check("a_pass",     32'(a_pass), 32'd1);
        check("a_sig_end",  32'(a_sig),  32'h3);
        check("a_cnt_end",  32'(a_cnt),  32'd1);

        for (int i = 0; i < 7; i++) begin
            bc_start = tbl[i].start;
            bc_valid = tbl[i].valid;
            bc_resp  = tbl[i].resp;
            tick();
            check($sformatf("b_sig[%0d]", i),  32'(b_sig),  32'(tbl[i].sig));
            check($sformatf("b_cnt[%0d]", i),  32'(b_cnt),  32'(tbl[i].cnt));
            check($sformatf("b_busy[%0d]", i), 32'(b_busy), 32'(tbl[i].busy));
            check($sformatf("b_done[%0d]", i), 32'(b_done), 32'(tbl[i].done));
            check($sformatf("b_pass[%0d]", i), 32'(b_pass), 32'(tbl[i].pass_b));
            check($sformatf("c_sig[%0d]", i),  32'(c_sig),  32'(tbl[i].sig));
            check($sformatf("c_done[%0d]", i), 32'(c_done), 32'(tbl[i].done));
            check($sformatf("c_pass[%0d]", i), 32'(c_pass), 32'(tbl[i].pass_c));
        end
        bc_valid = 1'b0;

        // c17 exhaustive with start pokes in RUN/CMP, then a back-to-back rerun.
        run_d(0, 1'b1, 1'b1);
        run_d(0, 1'b1, 1'b0);
        // Random responses: abort after 10 with rst, then a full run from IDLE.
        run_d(10, 1'b0, 1'b0);
        run_d(0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
